// File: rtl/riscv_pkg.sv
// Shared core constants: GPIO window base and register offsets.
// The load-data mux splits its address space on the same GPIO_BASE.
package riscv_pkg;

    localparam int GPIO_BASE = 4096;

    localparam logic [4:0] GPIO_OFS_DOUT = 5'h00;
    localparam logic [4:0] GPIO_OFS_DIR  = 5'h04;
    localparam logic [4:0] GPIO_OFS_DIN  = 5'h08;
    localparam logic [4:0] GPIO_OFS_IEN  = 5'h0C;
    localparam logic [4:0] GPIO_OFS_PEND = 5'h10;
    localparam logic [4:0] GPIO_OFS_TGL  = 5'h14;

    // Word index within the 32-byte window; slots 6 and 7 are reserved.
    typedef enum logic [2:0] {
        GPIO_REG_DOUT = GPIO_OFS_DOUT[4:2],
        GPIO_REG_DIR  = GPIO_OFS_DIR[4:2],
        GPIO_REG_DIN  = GPIO_OFS_DIN[4:2],
        GPIO_REG_IEN  = GPIO_OFS_IEN[4:2],
        GPIO_REG_PEND = GPIO_OFS_PEND[4:2],
        GPIO_REG_TGL  = GPIO_OFS_TGL[4:2],
        GPIO_REG_RSV6 = 3'd6,
        GPIO_REG_RSV7 = 3'd7
    } gpio_reg_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs into the core clock domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO peripheral: output/direction/interrupt registers,
// pin synchronisation with rising-edge capture, and registered read data.
module gpio_ctrl
    import riscv_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int BASE_ADDR = GPIO_BASE,
    parameter int GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     addr_i,
    input  logic              we_i,
    input  logic [DW-1:0]     wr_data_i,
    output logic [DW-1:0]     rd_data_o,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic [GPIO_W-1:0] gpio_oe_o,
    output logic              irq_o
);

    localparam logic [AW-1:0] LP_BASE = AW'(BASE_ADDR);

    logic [GPIO_W-1:0] r_dout;
    logic [GPIO_W-1:0] r_dir;
    logic [GPIO_W-1:0] r_ien;
    logic [GPIO_W-1:0] r_pend;
    logic [GPIO_W-1:0] r_prev;
    logic [DW-1:0]     r_rdata;

    logic              w_hit;
    logic              w_wr_en;
    gpio_reg_e         w_reg;
    logic [GPIO_W-1:0] w_wsel;
    logic [GPIO_W-1:0] w_sync;
    logic [GPIO_W-1:0] w_rise;
    logic [GPIO_W-1:0] w_clr;
    logic [GPIO_W-1:0] w_rsel;
    logic [DW-1:0]     w_rdata;
    logic              w_unused;

    sync_2ff #(
        .WIDTH(GPIO_W)
    ) u_pin_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (gpio_i),
        .q_o  (w_sync)
    );

    // The window is 32-byte aligned, so a hit is a match on the upper bits.
    assign w_hit    = (addr_i[AW-1:5] == LP_BASE[AW-1:5]);
    assign w_reg    = gpio_reg_e'(addr_i[4:2]);
    assign w_wr_en  = we_i & w_hit;
    assign w_wsel   = wr_data_i[GPIO_W-1:0];
    assign w_rise   = w_sync & ~r_prev;
    assign w_clr    = (w_wr_en && (w_reg == GPIO_REG_PEND)) ? w_wsel : '0;
    assign w_unused = ^{addr_i[1:0], wr_data_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= '0;
            r_dir  <= '0;
            r_ien  <= '0;
        end else if (w_wr_en) begin
            case (w_reg)
                GPIO_REG_DOUT: r_dout <= w_wsel;
                GPIO_REG_DIR:  r_dir  <= w_wsel;
                GPIO_REG_IEN:  r_ien  <= w_wsel;
                GPIO_REG_TGL:  r_dout <= r_dout ^ w_wsel;
                default: ;
            endcase
        end
    end

    // A fresh rising edge beats a same-cycle write-one-to-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_pend <= '0;
        end else begin
            r_prev <= w_sync;
            r_pend <= (r_pend & ~w_clr) | w_rise;
        end
    end

    always_comb begin
        w_rsel = '0;
        if (w_hit) begin
            case (w_reg)
                GPIO_REG_DOUT: w_rsel = r_dout;
                GPIO_REG_DIR:  w_rsel = r_dir;
                GPIO_REG_DIN:  w_rsel = w_sync;
                GPIO_REG_IEN:  w_rsel = r_ien;
                GPIO_REG_PEND: w_rsel = r_pend;
                default:       w_rsel = '0;
            endcase
        end
        w_rdata = '0;
        w_rdata[GPIO_W-1:0] = w_rsel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rdata;
        end
    end

    assign rd_data_o = r_rdata;
    assign gpio_o    = r_dout;
    assign gpio_oe_o = r_dir;
    assign irq_o     = |(r_pend & r_ien);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared against a register-map model.
module tb_gpio_ctrl;

    localparam int BASE = 4096;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdData;
    logic [7:0]  gpioIn;
    logic [7:0]  gpioOut;
    logic [7:0]  gpioOe;
    logic        irq;

    int checks = 0;
    int errors = 0;
    bit cmpEn  = 0;

    gpio_ctrl #(
        .AW       (32),
        .DW       (32),
        .BASE_ADDR(BASE),
        .GPIO_W   (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr_i   (addr),
        .we_i     (we),
        .wr_data_i(wdata),
        .rd_data_o(rdData),
        .gpio_i   (gpioIn),
        .gpio_o   (gpioOut),
        .gpio_oe_o(gpioOe),
        .irq_o    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the visible register map plus a history of the pin
    // values seen at the last three clock edges (index 0 = most recent).
    logic [7:0]  mDout, mDir, mIen, mPend;
    logic [7:0]  pinHist [0:2];
    logic [31:0] mRd;
    logic        mHit;
    logic [2:0]  mIdx;
    logic        mWr;
    logic [7:0]  mReadVal, mClr, mRise;

    assign mHit  = (addr >= 32'(BASE)) && (addr < 32'(BASE + 32));
    assign mIdx  = 3'((addr - 32'(BASE)) >> 2);
    assign mWr   = we && mHit;
    assign mClr  = (mWr && mIdx == 3'd4) ? wdata[7:0] : 8'h00;
    assign mRise = pinHist[1] & ~pinHist[2];

    always_comb begin
        mReadVal = 8'h00;
        case (mIdx)
            3'd0:    mReadVal = mDout;
            3'd1:    mReadVal = mDir;
            3'd2:    mReadVal = pinHist[1];
            3'd3:    mReadVal = mIen;
            3'd4:    mReadVal = mPend;
            default: mReadVal = 8'h00;
        endcase
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mDout      <= 8'h00;
            mDir       <= 8'h00;
            mIen       <= 8'h00;
            mPend      <= 8'h00;
            mRd        <= 32'h0;
            pinHist[0] <= 8'h00;
            pinHist[1] <= 8'h00;
            pinHist[2] <= 8'h00;
        end else begin
            mRd <= mHit ? {24'h0, mReadVal} : 32'h0;
            if (mWr && mIdx == 3'd0) mDout <= wdata[7:0];
            else if (mWr && mIdx == 3'd5) mDout <= mDout ^ wdata[7:0];
            if (mWr && mIdx == 3'd1) mDir <= wdata[7:0];
            if (mWr && mIdx == 3'd3) mIen <= wdata[7:0];
            mPend      <= (mPend & ~mClr) | mRise;
            pinHist[0] <= gpioIn;
            pinHist[1] <= pinHist[0];
            pinHist[2] <= pinHist[1];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every falling edge, all outputs are held against the model.
    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("model_rd_data", rdData, mRd);
            checkOutput("model_gpio_o", 32'(gpioOut), 32'(mDout));
            checkOutput("model_gpio_oe", 32'(gpioOe), 32'(mDir));
            checkOutput("model_irq", 32'(irq), 32'(|(mPend & mIen)));
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        we    = w;
        wdata = d;
    endtask

    task automatic readCheck(input logic [31:0] a, input logic [31:0] expected, input string name);
        applyStimulus(a, 1'b0, 32'h0);
        applyStimulus(32'h0, 1'b0, 32'h0);
        checkOutput(name, rdData, expected);
    endtask

    task automatic readAllZero(input string tag);
        for (int i = 0; i < 8; i++) begin
            readCheck(32'(BASE + 4 * i), 32'h0, $sformatf("%s_ofs%0d", tag, 4 * i));
        end
        readCheck(32'h0, 32'h0, {tag, "_addr0"});
    endtask

    initial begin
        addr   = 32'h0;
        we     = 1'b0;
        wdata  = 32'h0;
        gpioIn = 8'h00;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_rd", rdData, 32'h0);
        checkOutput("reset_gpio_o", 32'(gpioOut), 32'h0);
        checkOutput("reset_gpio_oe", 32'(gpioOe), 32'h0);
        checkOutput("reset_irq", 32'(irq), 32'h0);
        cmpEn = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        readAllZero("post_reset");
        checkOutput("idle_gpio_oe", 32'(gpioOe), 32'h0);
        checkOutput("idle_irq", 32'(irq), 32'h0);

        // Direction, data and toggle.
        applyStimulus(32'(BASE + 4), 1'b1, 32'hFFFF_FFFF);
        applyStimulus(32'(BASE), 1'b1, 32'h0000_00A5);
        applyStimulus(32'h0, 1'b0, 32'h0);
        checkOutput("dout_a5", 32'(gpioOut), 32'hA5);
        checkOutput("dir_ff", 32'(gpioOe), 32'hFF);
        applyStimulus(32'(BASE + 32'h14), 1'b1, 32'h0000_000F);
        applyStimulus(32'h0, 1'b0, 32'h0);
        checkOutput("toggle_aa", 32'(gpioOut), 32'hAA);
        readCheck(32'(BASE), 32'h0000_00AA, "read_dout_aa");
        readCheck(32'(BASE + 4), 32'h0000_00FF, "read_dir_upper_zero");
        readCheck(32'(BASE + 32'h14), 32'h0, "read_tgl_zero");

        // Pin 0 rises: DATA_IN after two edges, IRQ_PEND on the third.
        applyStimulus(32'(BASE + 8), 1'b0, 32'h0);
        gpioIn = 8'h01;
        applyStimulus(32'(BASE + 8), 1'b0, 32'h0);
        checkOutput("din_edge1", rdData, 32'h0);
        applyStimulus(32'(BASE + 8), 1'b0, 32'h0);
        checkOutput("din_edge2", rdData, 32'h0);
        applyStimulus(32'(BASE + 32'h10), 1'b0, 32'h0);
        checkOutput("din_edge3", rdData, 32'h1);
        checkOutput("irq_masked_e3", 32'(irq), 32'h0);
        applyStimulus(32'(BASE + 32'hC), 1'b1, 32'h1);
        checkOutput("pend_set", rdData, 32'h1);
        checkOutput("irq_masked", 32'(irq), 32'h0);
        applyStimulus(32'h0, 1'b0, 32'h0);
        checkOutput("irq_enabled", 32'(irq), 32'h1);

        // W1C coinciding with a new rising edge: the set wins.
        gpioIn = 8'h00;
        repeat (4) applyStimulus(32'h0, 1'b0, 32'h0);
        gpioIn = 8'h01;
        applyStimulus(32'h0, 1'b0, 32'h0);
        applyStimulus(32'(BASE + 32'h10), 1'b1, 32'h1);
        applyStimulus(32'(BASE + 32'h10), 1'b0, 32'h0);
        checkOutput("set_wins_irq", 32'(irq), 32'h1);
        applyStimulus(32'(BASE + 32'h10), 1'b1, 32'h1);
        checkOutput("set_wins_rd", rdData, 32'h1);
        applyStimulus(32'(BASE + 32'h10), 1'b0, 32'h0);
        checkOutput("w1c_irq_clear", 32'(irq), 32'h0);
        applyStimulus(32'h0, 1'b0, 32'h0);
        checkOutput("w1c_pend_clear", rdData, 32'h0);

        // Read-before-write and ignored out-of-window writes.
        applyStimulus(32'(BASE), 1'b1, 32'h11);
        applyStimulus(32'(BASE), 1'b1, 32'h22);
        applyStimulus(32'(BASE), 1'b0, 32'h0);
        checkOutput("rbw_old", rdData, 32'h11);
        applyStimulus(32'(BASE + 32'h20), 1'b1, 32'hFFFF_FFFF);
        checkOutput("rbw_new", rdData, 32'h22);
        applyStimulus(32'(BASE - 4), 1'b1, 32'hFFFF_FFFF);
        applyStimulus(32'(BASE + 32'h18), 1'b1, 32'hFFFF_FFFF);
        readCheck(32'(BASE), 32'h22, "nonhit_dout");
        checkOutput("nonhit_gpio_o", 32'(gpioOut), 32'h22);
        readCheck(32'(BASE + 32'h20), 32'h0, "nonhit_read");
        readCheck(32'(BASE + 32'h1C), 32'h0, "reserved_read");

        // Asynchronous reset in the middle of activity.
        applyStimulus(32'(BASE), 1'b1, 32'hFF);
        gpioIn = 8'h00;
        repeat (3) applyStimulus(32'h0, 1'b0, 32'h0);
        gpioIn = 8'h03;
        repeat (4) applyStimulus(32'h0, 1'b0, 32'h0);
        checkOutput("pre_reset_irq", 32'(irq), 32'h1);
        checkOutput("pre_reset_dout", 32'(gpioOut), 32'hFF);
        applyStimulus(32'(BASE + 32'h10), 1'b0, 32'h0);
        #3 rst_n  = 1'b0;
        gpioIn = 8'h00;
        #1;
        checkOutput("async_rst_gpio_o", 32'(gpioOut), 32'h0);
        checkOutput("async_rst_gpio_oe", 32'(gpioOe), 32'h0);
        checkOutput("async_rst_irq", 32'(irq), 32'h0);
        checkOutput("async_rst_rd", rdData, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        readAllZero("after_async_reset");

        // Randomized traffic judged by the model alone.
        for (int n = 0; n < 3000; n++) begin
            int sel;
            logic [31:0] a;
            sel = int'($urandom_range(0, 15));
            if (sel < 12) a = 32'(BASE) + 32'($urandom_range(0, 31));
            else if (sel == 12) a = $urandom;
            else if (sel == 13) a = 32'(BASE) - 32'($urandom_range(1, 8));
            else if (sel == 14) a = 32'(BASE + 32) + 32'($urandom_range(0, 7));
            else a = 32'h0;
            applyStimulus(a, ($urandom_range(0, 2) == 0), $urandom);
            if ($urandom_range(0, 3) == 0) gpioIn = 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end

        applyStimulus(32'h0, 1'b0, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
